ex_muldiv_unit: RTL

// - Parametrised multi-cycle multiply/divide unit beside the EX stage; owns the HI/LO register pair.
// - Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
// - Drives a stall request that holds IF..EX while an iterative op runs.
// - Final HI/LO feed MFHI/MFLO through the logic/move path.

---
 rtl/ex_muldiv_unit_if.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Handshake/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic              annul_i;
  logic              stall_req_o;
  logic              done_o;
  logic              div_zero_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  stall_req_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output stall_req_o, done_o, div_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; MTHI/MTLO complete in one cycle.
// Define MDU_MADD_EN to enable MADD/MSUB (signed multiply-accumulate into {HI,LO}).
//
// state  | meaning
// S_IDLE | waiting; moves commit here, iterative ops are accepted here
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIX  | sign correction / accumulate, commit HI/LO
// S_DONE | done_o pulse, back to S_IDLE
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic               clk,
  input logic               rst,
  ex_muldiv_unit_if.slave   bus
);
  localparam int W = DATA_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_opnd;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_is_div;
  logic             r_acc_add;
  logic             r_acc_sub;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_done;
  logic             r_dz;

  logic             w_op_mul;
  logic             w_op_div;
  logic             w_op_madd;
  logic             w_signed;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic [W:0]       w_mul_sum;
  logic [2*W-1:0]   w_mul_next;
  logic [W:0]       w_div_shift;
  logic [W:0]       w_div_trial;
  logic [2*W-1:0]   w_div_next;
  logic [2*W-1:0]   w_prod_s;
  logic [2*W-1:0]   w_mul_res;
  logic [W-1:0]     w_fix_hi;
  logic [W-1:0]     w_fix_lo;

  assign w_op_madd = MADD_EN && (bus.op_i == OP_MADD || bus.op_i == OP_MSUB);
  assign w_op_mul  = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU) || w_op_madd;
  assign w_op_div  = (bus.op_i == OP_DIV) || (bus.op_i == OP_DIVU);
  assign w_signed  = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV) || w_op_madd;
  assign w_a_mag   = (w_signed && bus.opa_i[W-1]) ? -bus.opa_i : bus.opa_i;
  assign w_b_mag   = (w_signed && bus.opb_i[W-1]) ? -bus.opb_i : bus.opb_i;

  // Multiply: r_acc = {partial, multiplier}; add into the top half then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opnd : {W{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Divide: r_acc = {remainder, dividend/quotient}; remainder < divisor so W+1 bits suffice.
  assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_trial[W] ? {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                      : {w_div_trial[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_prod_s = r_neg_lo ? -r_acc : r_acc;

  always_comb begin
    w_mul_res = w_prod_s;
    if (r_acc_add)      w_mul_res = {r_hi, r_lo} + w_prod_s;
    else if (r_acc_sub) w_mul_res = {r_hi, r_lo} - w_prod_s;
    if (r_is_div) begin
      w_fix_hi = r_neg_hi ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
      w_fix_lo = r_neg_lo ? -r_acc[W-1:0]   : r_acc[W-1:0];
    end else begin
      w_fix_hi = w_mul_res[2*W-1:W];
      w_fix_lo = w_mul_res[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_hi  <= 1'b0;
      r_is_div  <= 1'b0;
      r_acc_add <= 1'b0;
      r_acc_sub <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else if (bus.annul_i) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_dz   <= 1'b0;
          if (bus.start_i) begin
            if (bus.op_i == OP_MTHI) begin
              r_hi <= bus.opa_i;
            end else if (bus.op_i == OP_MTLO) begin
              r_lo <= bus.opa_i;
            end else if (w_op_mul) begin
              r_acc     <= {{W{1'b0}}, w_b_mag};
              r_opnd    <= w_a_mag;
              r_neg_lo  <= w_signed && (bus.opa_i[W-1] ^ bus.opb_i[W-1]);
              r_neg_hi  <= 1'b0;
              r_is_div  <= 1'b0;
              r_acc_add <= w_op_madd && (bus.op_i == OP_MADD);
              r_acc_sub <= w_op_madd && (bus.op_i == OP_MSUB);
              r_cnt     <= CNT_LOAD;
              r_state   <= S_MUL;
            end else if (w_op_div) begin
              if (bus.opb_i == '0) begin
                r_done  <= 1'b1;
                r_dz    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_acc     <= {{W{1'b0}}, w_a_mag};
                r_opnd    <= w_b_mag;
                r_neg_lo  <= w_signed && (bus.opa_i[W-1] ^ bus.opb_i[W-1]);
                r_neg_hi  <= w_signed && bus.opa_i[W-1];
                r_is_div  <= 1'b1;
                r_acc_add <= 1'b0;
                r_acc_sub <= 1'b0;
                r_cnt     <= CNT_LOAD;
                r_state   <= S_DIV;
              end
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_DIV: begin
          r_acc <= w_div_next;
          if (r_cnt == '0) r_state <= S_FIX;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_req_o = ~bus.annul_i &
                           (((r_state == S_IDLE) & bus.start_i & (w_op_mul | w_op_div)) |
                            (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_FIX));
  assign bus.done_o      = r_done;
  assign bus.div_zero_o  = r_dz;
  assign bus.hi_o        = r_hi;
  assign bus.lo_o        = r_lo;
endmodule
